// File: rtl/qdec_ctx_mem_arb_pkg.sv
// Shared types for the CABAC context-memory arbiter.
// Address/data widths, starvation limit and grant encoding.
package qdec_ctx_mem_arb_pkg;

  localparam int CTX_ADDR_W     = 10;
  localparam int CTX_DATA_W     = 8;
  localparam int CTX_STARVE_MAX = 4;

  typedef struct packed {
    logic       mps;
    logic [6:0] state;
  } t_ctx_word_s;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_RD,
    GNT_WB,
    GNT_INIT
  } t_ctx_grant_e;

endpackage

// File: rtl/qdec_ctx_mem_arb_if.sv
// Request/response and memory-side bundle of the context arbiter.
// slave = arbiter view, master = clients plus memory.
interface qdec_ctx_mem_arb_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_wdata;
  logic              init_vld;
  logic              init_rdy;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_vld;
  logic              rd_rdy;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_vld;
  logic [ADDR_W-1:0] upd_addr;
  logic [DATA_W-1:0] upd_data;
  logic              upd_vld;
  logic              upd_rdy;
  logic [ADDR_W-1:0] ctx_addr;
  logic [DATA_W-1:0] ctx_wdata;
  logic              ctx_we;
  logic              ctx_re;
  logic [DATA_W-1:0] ctx_rdata;
  logic              busy;

  modport slave (
    input  init_addr, init_wdata, init_vld,
    input  rd_addr, rd_vld,
    input  upd_addr, upd_data, upd_vld,
    input  ctx_rdata,
    output init_rdy, rd_rdy, rd_data, rd_data_vld,
    output upd_rdy,
    output ctx_addr, ctx_wdata, ctx_we, ctx_re,
    output busy
  );

  modport master (
    output init_addr, init_wdata, init_vld,
    output rd_addr, rd_vld,
    output upd_addr, upd_data, upd_vld,
    output ctx_rdata,
    input  init_rdy, rd_rdy, rd_data, rd_data_vld,
    input  upd_rdy,
    input  ctx_addr, ctx_wdata, ctx_we, ctx_re,
    input  busy
  );
endinterface

// File: rtl/qdec_ctx_mem_arb.sv
// Single-port context memory arbiter: init writer, state fetch,
// posted state update with read bypass and starvation guard.
module qdec_ctx_mem_arb
  import qdec_ctx_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = CTX_ADDR_W,
  parameter int DATA_W     = CTX_DATA_W,
  parameter int STARVE_MAX = CTX_STARVE_MAX
) (
  input logic clk,
  input logic rst_n,
  qdec_ctx_mem_arb_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic              wb_vld_q, wb_vld_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              rvld_q, rvld_d;
  logic              byp_q, byp_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;

  t_ctx_grant_e gnt;
  logic starved, drain, rd_g, init_g;
  logic upd_fire, hit_a, hit_b;

  assign starved  = wb_vld_q & (starve_q == SW'(STARVE_MAX));
  assign drain    = wb_vld_q & (starved | ~bus.rd_vld);
  assign rd_g     = bus.rd_vld & ~starved;
  assign init_g   = bus.init_vld & ~wb_vld_q & ~bus.rd_vld;
  assign upd_fire = bus.upd_vld & ~wb_vld_q;
  assign hit_a    = upd_fire & (bus.upd_addr == bus.rd_addr);
  assign hit_b    = wb_vld_q & (wb_addr_q == bus.rd_addr);

  always_comb begin
    gnt = GNT_NONE;
    unique case (1'b1)
      drain:   gnt = GNT_WB;
      rd_g:    gnt = GNT_RD;
      init_g:  gnt = GNT_INIT;
      default: gnt = GNT_NONE;
    endcase
  end

  always_comb begin
    bus.ctx_we    = 1'b0;
    bus.ctx_re    = 1'b0;
    bus.ctx_addr  = '0;
    bus.ctx_wdata = '0;
    unique case (gnt)
      GNT_WB: begin
        bus.ctx_we    = 1'b1;
        bus.ctx_addr  = wb_addr_q;
        bus.ctx_wdata = wb_data_q;
      end
      GNT_RD: begin
        bus.ctx_re   = 1'b1;
        bus.ctx_addr = bus.rd_addr;
      end
      GNT_INIT: begin
        bus.ctx_we    = 1'b1;
        bus.ctx_addr  = bus.init_addr;
        bus.ctx_wdata = bus.init_wdata;
      end
      default: ;
    endcase
  end

  assign bus.rd_rdy      = (gnt == GNT_RD);
  assign bus.init_rdy    = (gnt == GNT_INIT);
  assign bus.upd_rdy     = ~wb_vld_q;
  assign bus.rd_data_vld = rvld_q;
  assign bus.busy        = wb_vld_q | rvld_q;
  assign bus.rd_data     = !rvld_q ? '0 :
                           byp_q   ? byp_data_q :
                                     bus.ctx_rdata;

  always_comb begin
    wb_vld_d   = wb_vld_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    starve_d   = starve_q;
    rvld_d     = (gnt == GNT_RD);
    byp_d      = byp_q;
    byp_data_d = byp_data_q;
    if (gnt == GNT_WB) begin
      wb_vld_d = 1'b0;
      starve_d = '0;
    end else if (wb_vld_q && !starved) begin
      starve_d = starve_q + 1'b1;
    end
    // update is ordered ahead of a read in the same cycle
    if (upd_fire) begin
      wb_vld_d  = 1'b1;
      wb_addr_d = bus.upd_addr;
      wb_data_d = bus.upd_data;
    end
    if (gnt == GNT_RD) begin
      byp_d      = hit_a | hit_b;
      byp_data_d = hit_a ? bus.upd_data : wb_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_vld_q   <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      starve_q   <= '0;
      rvld_q     <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      wb_vld_q   <= wb_vld_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      starve_q   <= starve_d;
      rvld_q     <= rvld_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end

endmodule

// File: tb/tb_qdec_ctx_mem_arb.sv
// Bench for the context arbiter: memory model, value-level
// reference of the latest context state, directed and random traffic.
module tb_qdec_ctx_mem_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qdec_ctx_mem_arb_if b ();

  qdec_ctx_mem_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  logic [7:0] mem [1024];
  logic [7:0] mrd = 8'h00;
  assign b.ctx_rdata = mrd;

  always @(posedge clk) begin
    if (b.ctx_we) mem[b.ctx_addr] <= b.ctx_wdata;
    if (b.ctx_re) mrd <= mem[b.ctx_addr];
  end

  int vectors = 0;
  int errors  = 0;

  // reference: latest architectural value per context
  logic [7:0] shadow [1024];
  bit         pend  = 0;
  logic [9:0] p_addr = '0;
  logic [7:0] p_data = '0;
  int         waitc = 0;
  bit         e_rvld = 0;
  logic [7:0] e_rdata = '0;
  int         we_cnt = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic clr();
    b.init_vld = 0; b.rd_vld = 0; b.upd_vld = 0;
  endtask

  task automatic cycle();
    bit st, rg, wg, ig, uf;
    #1;
    st = pend && waitc >= 4;
    rg = b.rd_vld && !st;
    wg = pend && (st || !b.rd_vld);
    ig = b.init_vld && !pend && !b.rd_vld;
    uf = b.upd_vld && !pend;
    chk("rd_rdy", b.rd_rdy, rg);
    chk("init_rdy", b.init_rdy, ig);
    chk("upd_rdy", b.upd_rdy, !pend);
    chk("ctx_we", b.ctx_we, wg || ig);
    chk("ctx_re", b.ctx_re, rg);
    if (rg) chk("rd_addr_out", b.ctx_addr, b.rd_addr);
    if (wg) begin
      chk("wb_addr_out", b.ctx_addr, p_addr);
      chk("wb_wdata_out", b.ctx_wdata, p_data);
    end
    if (ig) begin
      chk("init_addr_out", b.ctx_addr, b.init_addr);
      chk("init_wdata_out", b.ctx_wdata, b.init_wdata);
    end
    chk("rd_data_vld", b.rd_data_vld, e_rvld);
    if (e_rvld) chk("rd_data", b.rd_data, e_rdata);
    chk("busy", b.busy, pend || e_rvld);
    if (b.ctx_we) we_cnt++;
    e_rvld = rg;
    if (rg)
      e_rdata = (uf && b.upd_addr == b.rd_addr) ?
                b.upd_data : shadow[b.rd_addr];
    if (ig) shadow[b.init_addr] = b.init_wdata;
    if (uf) shadow[b.upd_addr] = b.upd_data;
    if (wg) begin
      pend = 0; waitc = 0;
    end else if (pend && waitc < 4) begin
      waitc++;
    end
    if (uf) begin
      pend = 1; p_addr = b.upd_addr;
      p_data = b.upd_data; waitc = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  bit rr [8];
  bit ur [8];
  bit ir [8];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      shadow[i] = '0;
      mem[i] = '0;
    end
    clr();
    b.init_addr = '0; b.init_wdata = '0;
    b.rd_addr = '0; b.upd_addr = '0; b.upd_data = '0;

    // reset state
    @(negedge clk); #1;
    chk("rst_upd_rdy", b.upd_rdy, 1);
    chk("rst_ctx_we", b.ctx_we, 0);
    chk("rst_ctx_re", b.ctx_re, 0);
    chk("rst_rvld", b.rd_data_vld, 0);
    chk("rst_busy", b.busy, 0);
    @(negedge clk);
    rst_n = 1;
    cycle();

    // reset mid-read drops update and read
    b.upd_vld = 1; b.upd_addr = 10'h005; b.upd_data = 8'h11;
    cycle();
    clr();
    b.rd_vld = 1; b.rd_addr = 10'h005;
    #1 chk("mid_rd_rdy", b.rd_rdy, 1);
    @(posedge clk); #1;
    rst_n = 0;
    clr();
    #1;
    chk("mid_rst_rvld", b.rd_data_vld, 0);
    chk("mid_rst_busy", b.busy, 0);
    chk("mid_rst_upd_rdy", b.upd_rdy, 1);
    chk("mid_rst_we", b.ctx_we, 0);
    chk("mid_rst_re", b.ctx_re, 0);
    pend = 0; waitc = 0; e_rvld = 0;
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1;
    cycle();

    // init sweep
    we_cnt = 0;
    for (int a = 0; a < 1024; a++) begin
      b.init_vld = 1;
      b.init_addr = 10'(a);
      b.init_wdata = 8'(a);
      cycle();
    end
    clr();
    chk("init_we_cnt", we_cnt, 1024);
    b.rd_vld = 1; b.rd_addr = 10'h155;
    cycle();
    clr();
    #1 chk("rd_155", b.rd_data, 8'h55);
    cycle();

    // bypass A
    b.upd_vld = 1; b.upd_addr = 10'h020; b.upd_data = 8'h3A;
    b.rd_vld = 1; b.rd_addr = 10'h020;
    cycle();
    clr();
    #1 chk("byp_a", b.rd_data, 8'h3A);
    cycle();
    cycle();
    chk("mem_020", mem[10'h020], 8'h3A);

    // bypass B, then a plain memory read
    b.upd_vld = 1; b.upd_addr = 10'h021; b.upd_data = 8'h47;
    cycle();
    clr();
    b.rd_vld = 1; b.rd_addr = 10'h021;
    cycle();
    b.rd_addr = 10'h022;
    #1 chk("byp_b", b.rd_data, 8'h47);
    cycle();
    clr();
    #1 chk("rd_022", b.rd_data, 8'h22);
    repeat (3) cycle();

    // starvation under continuous reads
    b.upd_vld = 1; b.upd_addr = 10'h030; b.upd_data = 8'h5C;
    cycle();
    clr();
    b.rd_vld = 1;
    for (int i = 0; i < 7; i++) begin
      b.rd_addr = 10'($urandom_range(16'h2E, 16'h32));
      #1;
      rr[i] = b.rd_rdy;
      ur[i] = b.upd_rdy;
      cycle();
    end
    clr();
    for (int i = 0; i < 4; i++) chk("starve_rd", rr[i], 1);
    chk("starve_drain_rd_rdy", rr[4], 0);
    chk("starve_drain_upd_rdy", ur[4], 0);
    chk("starve_after_rd_rdy", rr[5], 1);
    chk("starve_after_upd_rdy", ur[5], 1);
    cycle();

    // contention: rd > wb > init
    b.upd_vld = 1; b.upd_addr = 10'h040; b.upd_data = 8'h66;
    cycle();
    clr();
    b.init_vld = 1; b.init_addr = 10'h041; b.init_wdata = 8'h99;
    b.rd_vld = 1; b.rd_addr = 10'h042;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) b.rd_vld = 0;
      #1;
      rr[i] = b.rd_rdy;
      ir[i] = b.init_rdy;
      ur[i] = b.upd_rdy;
      cycle();
    end
    clr();
    for (int i = 0; i < 3; i++) begin
      chk("cont_rd", rr[i], 1);
      chk("cont_init_stall", ir[i], 0);
    end
    chk("cont_wb_first", ir[3], 0);
    chk("cont_wb_drain", ur[3], 0);
    chk("cont_init_last", ir[4], 1);
    repeat (2) cycle();

    // random mixed traffic on a small address window
    for (int n = 0; n < 3000; n++) begin
      b.rd_vld = ($urandom % 2) == 0;
      b.rd_addr = 10'($urandom % 12);
      b.upd_vld = ($urandom % 3) == 0;
      b.upd_addr = 10'($urandom % 12);
      b.upd_data = 8'($urandom);
      b.init_vld = ($urandom % 4) == 0;
      b.init_addr = 10'($urandom % 12);
      b.init_wdata = 8'($urandom);
      cycle();
    end
    clr();
    repeat (8) cycle();
    for (int a = 0; a < 12; a++)
      chk("final_mem", mem[a], shadow[a]);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
